// File: rtl/seg_src_sched_pkg.sv
// Shared types and constants for the Seg7x16 source scheduler.
// Used by the scheduler top and the round-robin helper.
package seg_src_sched_pkg;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_AUTO   = 2'd1,
        ST_MANUAL = 2'd2,
        ST_HALTED = 2'd3
    } state_t;

    localparam int          NSRC          = 4;
    localparam logic [31:0] BLANK_VAL_DEF = 32'hFFFF_FFFF;

endpackage

// File: rtl/seg_src_sched_rr_next_valid.sv
// Combinational round-robin search: first valid index after i_cur,
// trying cur+1, cur+2, cur+3 (mod 4). o_next falls back to i_cur.
module rr_next_valid
    import seg_src_sched_pkg::*;
(
    input  logic [1:0]      i_cur,
    input  logic [NSRC-1:0] i_valid,
    output logic [1:0]      o_next,
    output logic            o_found
);

    // Walk from the farthest candidate down so the nearest one wins.
    always_comb begin
        o_next  = i_cur;
        o_found = 1'b0;
        for (int k = NSRC - 1; k >= 1; k--) begin
            if (i_valid[i_cur + 2'(k)]) begin
                o_next  = i_cur + 2'(k);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_src_sched.sv
// Picks which CPU debug word drives Seg7x16: auto rotation on a dwell
// timer, manual pinning, and a frozen snapshot once the CPU halts.
//
// state     | meaning
// ST_INIT   | first cycle after reset, picks AUTO or MANUAL
// ST_AUTO   | rotate among valid sources every DWELL_TICKS ticks
// ST_MANUAL | show i_man_sel, dwell counter parked at 0
// ST_HALTED | snapshot frozen until reset
module seg_src_sched
    import seg_src_sched_pkg::*;
#(
    parameter int          DWELL_TICKS = 1000,
    parameter int          HALT_SRC    = 0,
    parameter logic [31:0] BLANK_VAL   = BLANK_VAL_DEF
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_tick,
    input  logic [127:0]  i_src_data,
    input  logic [3:0]    i_src_valid,
    input  logic          i_mode_auto,
    input  logic [1:0]    i_man_sel,
    input  logic          i_halt,
    output logic          o_seg_en,
    output logic [31:0]   o_seg_data,
    output logic [1:0]    o_cur_sel,
    output logic          o_halted
);

    localparam logic [15:0] LP_LAST = 16'(DWELL_TICKS - 1);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [1:0]  r_cur_sel, w_sel_nxt;
    logic [31:0] r_seg_data, w_data_nxt;
    logic        r_seg_en, r_halted, w_halted_nxt;

    logic [1:0]  w_rr_next;
    logic        w_rr_found;
    logic [1:0]  w_adv_sel;
    logic [31:0] w_live_data, w_snap_data;
    logic        w_cur_valid;

    rr_next_valid u_rr (
        .i_cur   (r_cur_sel),
        .i_valid (i_src_valid),
        .o_next  (w_rr_next),
        .o_found (w_rr_found)
    );

    assign w_adv_sel   = w_rr_found ? w_rr_next : r_cur_sel;
    assign w_cur_valid = i_src_valid[r_cur_sel];
    assign w_live_data = w_cur_valid ? i_src_data[{r_cur_sel, 5'd0} +: 32] : BLANK_VAL;
    assign w_snap_data = i_src_valid[HALT_SRC] ? i_src_data[HALT_SRC*32 +: 32] : BLANK_VAL;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= ST_INIT;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT:   w_state_nxt = i_mode_auto ? ST_AUTO : ST_MANUAL;
            ST_AUTO: begin
                if (i_halt)            w_state_nxt = ST_HALTED;
                else if (!i_mode_auto) w_state_nxt = ST_MANUAL;
            end
            ST_MANUAL: begin
                if (i_halt)           w_state_nxt = ST_HALTED;
                else if (i_mode_auto) w_state_nxt = ST_AUTO;
            end
            default:   w_state_nxt = ST_HALTED;
        endcase
    end

    // Priority inside AUTO: halt > mode change > invalid current > expiry.
    always_comb begin
        w_cnt_nxt    = r_cnt;
        w_sel_nxt    = r_cur_sel;
        w_data_nxt   = r_seg_data;
        w_halted_nxt = r_halted;
        if (r_state == ST_AUTO || r_state == ST_MANUAL) begin
            if (i_halt) begin
                w_data_nxt   = w_snap_data;
                w_sel_nxt    = 2'(HALT_SRC);
                w_halted_nxt = 1'b1;
            end else begin
                w_data_nxt = w_live_data;
                if (r_state == ST_MANUAL) begin
                    w_sel_nxt = i_man_sel;
                    w_cnt_nxt = '0;
                end else if (!i_mode_auto) begin
                    w_cnt_nxt = '0;
                end else if (!w_cur_valid) begin
                    w_cnt_nxt = '0;
                    w_sel_nxt = w_adv_sel;
                end else if (i_tick) begin
                    if (r_cnt == LP_LAST) begin
                        w_cnt_nxt = '0;
                        w_sel_nxt = w_adv_sel;
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt      <= '0;
            r_cur_sel  <= '0;
            r_seg_data <= BLANK_VAL;
            r_seg_en   <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_cur_sel  <= w_sel_nxt;
            r_seg_data <= w_data_nxt;
            r_seg_en   <= 1'b1;
            r_halted   <= w_halted_nxt;
        end
    end

    assign o_seg_en   = r_seg_en;
    assign o_seg_data = r_seg_data;
    assign o_cur_sel  = r_cur_sel;
    assign o_halted   = r_halted;

endmodule

// File: tb/tb_seg_src_sched.sv
// Directed plus randomized bench for seg_src_sched, checked every cycle
// against a behavioural model of the display scheduling rules.
module tb_seg_src_sched;

    localparam int          D  = 3;
    localparam int          HS = 0;
    localparam logic [31:0] BL = 32'hFFFF_FFFF;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tick = 1'b0;
    logic [127:0] src_data = '0;
    logic [3:0]   src_valid = 4'hF;
    logic         mode_auto = 1'b1;
    logic [1:0]   man_sel = 2'd0;
    logic         halt = 1'b0;
    logic         o_seg_en;
    logic [31:0]  o_seg_data;
    logic [1:0]   o_cur_sel;
    logic         o_halted;

    int total = 0;
    int bad   = 0;

    // model: phase 0=just reset, 1=rotating, 2=pinned, 3=frozen
    int          m_phase, m_sel, m_cnt;
    logic [31:0] m_data;
    logic        m_en, m_halted;

    seg_src_sched #(.DWELL_TICKS(D), .HALT_SRC(HS), .BLANK_VAL(BL)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_tick      (tick),
        .i_src_data  (src_data),
        .i_src_valid (src_valid),
        .i_mode_auto (mode_auto),
        .i_man_sel   (man_sel),
        .i_halt      (halt),
        .o_seg_en    (o_seg_en),
        .o_seg_data  (o_seg_data),
        .o_cur_sel   (o_cur_sel),
        .o_halted    (o_halted)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] src_word(int i);
        return src_data[i*32 +: 32];
    endfunction

    function automatic int next_valid(int cur);
        for (int k = 1; k <= 3; k++) begin
            if (src_valid[(cur + k) % 4]) return (cur + k) % 4;
        end
        return cur;
    endfunction

    task automatic model_update();
        if (rst) begin
            m_phase = 0; m_sel = 0; m_cnt = 0; m_data = BL; m_en = 1'b0; m_halted = 1'b0;
            return;
        end
        m_en = 1'b1;
        if (m_phase == 0) begin
            m_phase = mode_auto ? 1 : 2;
        end else if (m_phase == 3) begin
            // frozen
        end else if (halt) begin
            m_data = src_valid[HS] ? src_word(HS) : BL;
            m_sel = HS; m_halted = 1'b1; m_phase = 3;
        end else begin
            m_data = src_valid[m_sel] ? src_word(m_sel) : BL;
            if (m_phase == 2) begin
                m_sel = int'(man_sel); m_cnt = 0;
                if (mode_auto) m_phase = 1;
            end else if (!mode_auto) begin
                m_phase = 2; m_cnt = 0;
            end else if (!src_valid[m_sel]) begin
                m_cnt = 0; m_sel = next_valid(m_sel);
            end else if (tick) begin
                if (m_cnt == D - 1) begin
                    m_cnt = 0; m_sel = next_valid(m_sel);
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        chk("seg_data", o_seg_data, m_data);
        chk("cur_sel", {30'b0, o_cur_sel}, 32'(m_sel));
        chk("seg_en", {31'b0, o_seg_en}, {31'b0, m_en});
        chk("halted", {31'b0, o_halted}, {31'b0, m_halted});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) step();
        chk("rst_seg_en", {31'b0, o_seg_en}, 32'd0);
        chk("rst_blank", o_seg_data, BL);
        rst = 1'b0;
    endtask

    logic [31:0] seq[$];
    logic [31:0] prev;
    logic [31:0] exp_seq [5];

    initial begin
        // reset and auto rotation
        src_data  = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'hA060_2880};
        src_valid = 4'hF; mode_auto = 1'b1; tick = 1'b0;
        do_reset();
        step();
        chk("seg_en_after_rst", {31'b0, o_seg_en}, 32'd1);
        chk("cur_sel_after_rst", {30'b0, o_cur_sel}, 32'd0);
        prev = BL;
        for (int i = 0; i < 60; i++) begin
            tick = (i % 4 == 0);
            step();
            if (o_seg_data !== prev) begin
                seq.push_back(o_seg_data);
                prev = o_seg_data;
            end
        end
        tick = 1'b0;
        exp_seq = '{32'hA060_2880, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'hA060_2880};
        for (int k = 0; k < 5; k++)
            chk("auto_seq", (k < seq.size()) ? seq[k] : 32'h0, exp_seq[k]);

        // skip invalid sources
        src_valid = 4'b1010; tick = 1'b1;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step();
            if (o_cur_sel == 2'd1 && i > 4) break;
        end
        chk("wait_sel1", {30'b0, o_cur_sel}, 32'd1);
        src_valid = 4'b1000;
        step();
        chk("drop_valid_sel", {30'b0, o_cur_sel}, 32'd3);
        repeat (6) step();

        // manual mode
        src_valid = 4'hF; tick = 1'b0; mode_auto = 1'b0; man_sel = 2'd2;
        src_data[2*32 +: 32] = 32'h0000_0001;
        repeat (3) step();
        chk("manual_data", o_seg_data, 32'h0000_0001);
        src_valid = 4'b1101; man_sel = 2'd1;
        repeat (2) step();
        chk("manual_invalid", o_seg_data, BL);

        // halt on dwell expiry
        src_valid = 4'hF; mode_auto = 1'b1; tick = 1'b0;
        src_data[31:0] = 32'h1234_5678;
        do_reset();
        step();
        tick = 1'b1;
        repeat (2) step();
        halt = 1'b1;
        step();
        chk("halt_data", o_seg_data, 32'h1234_5678);
        chk("halt_sel", {30'b0, o_cur_sel}, 32'd0);
        chk("halt_flag", {31'b0, o_halted}, 32'd1);
        halt = 1'b0; src_data[31:0] = 32'hDEAD_BEEF; mode_auto = 1'b0;
        repeat (5) step();
        chk("frozen_data", o_seg_data, 32'h1234_5678);
        chk("frozen_sel", {30'b0, o_cur_sel}, 32'd0);

        // reset out of halt
        rst = 1'b1;
        step();
        chk("rst_halt_flag", {31'b0, o_halted}, 32'd0);
        chk("rst_halt_data", o_seg_data, BL);
        rst = 1'b0; mode_auto = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick = ($urandom_range(0, 1) == 1);
            step();
        end

        // randomized soak
        for (int i = 0; i < 1500; i++) begin
            tick = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) src_valid = 4'($urandom);
            if ($urandom_range(0, 3) == 0) src_data[$urandom_range(0, 3)*32 +: 32] = $urandom;
            if ($urandom_range(0, 19) == 0) mode_auto = ~mode_auto;
            man_sel = 2'($urandom);
            halt = ($urandom_range(0, 59) == 0);
            rst  = ($urandom_range(0, 79) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
